// File: rtl/cfa_pkg.sv
// Shared definitions for the CFA frame-scan path: default geometry,
// Bayer phase encodings and the scan sequencer state encoding.
package cfa_pkg;

  localparam int unsigned CFA_WIDTH  = 256;
  localparam int unsigned CFA_HEIGHT = 512;
  localparam int unsigned CFA_ADDR_W = 17;

  typedef enum logic [1:0] {
    CFA_R  = 2'b00,
    CFA_GR = 2'b01,
    CFA_GB = 2'b10,
    CFA_B  = 2'b11
  } cfa_phase_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_DRAIN = 2'b10,
    S_DONE  = 2'b11
  } scan_state_e;

endpackage

// File: rtl/cfa_rc_counter.sv
// Raster row/column counter: column wraps into row, and it parks on the last
// pixel instead of wrapping to the start of the frame.
module cfa_rc_counter #(
  parameter int unsigned WIDTH  = 256,
  parameter int unsigned HEIGHT = 512,
  parameter int unsigned COL_W  = 8,
  parameter int unsigned ROW_W  = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last
);

  logic col_end;

  assign col_end = (col == COL_W'(WIDTH - 1));
  assign last    = col_end && (row == ROW_W'(HEIGHT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (en && !last) begin
      if (col_end) begin
        col <= '0;
        row <= row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/cfa_scan_ctrl.sv
// Frame-scan sequencer: walks pixel memory in raster order under a
// start/busy/done handshake and emits sideband tags aligned to RAM read data.
module cfa_scan_ctrl
  import cfa_pkg::*;
#(
  parameter int unsigned WIDTH  = CFA_WIDTH,
  parameter int unsigned HEIGHT = CFA_HEIGHT,
  parameter int unsigned ADDR_W = CFA_ADDR_W,
  parameter int unsigned COL_W  = $clog2(WIDTH),
  parameter int unsigned ROW_W  = $clog2(HEIGHT),
  parameter logic [1:0]  BAYER  = CFA_R
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              hold,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              tag_valid,
  output logic [ROW_W-1:0]  tag_row,
  output logic [COL_W-1:0]  tag_col,
  output logic [1:0]        tag_phase,
  output logic              tag_sof,
  output logic              tag_eof,
  output logic              tag_sol,
  output logic              tag_eol,
  output logic              busy,
  output logic              done
);

  scan_state_e      state;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic             last;
  logic             issue;
  logic             cnt_clr;

  assign issue    = (state == S_RUN) && !hold;
  assign cnt_clr  = abort || (state != S_RUN);
  assign mem_en   = issue;
  assign mem_addr = ADDR_W'({row, col});
  assign busy     = (state != S_IDLE);
  // An abort landing in DONE retracts the pulse so an aborted frame never reports done.
  assign done     = (state == S_DONE) && !abort;

  cfa_rc_counter #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_rc (
    .clk (clk),
    .rst (rst),
    .en  (issue),
    .clr (cnt_clr),
    .row (row),
    .col (col),
    .last(last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else if (abort) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state <= S_RUN;
        S_RUN:   if (issue && last) state <= S_DRAIN;
        S_DRAIN: state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Tags capture the issuing address so they line up with 1-cycle RAM latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_valid <= 1'b0;
      tag_row   <= '0;
      tag_col   <= '0;
      tag_phase <= '0;
      tag_sof   <= 1'b0;
      tag_eof   <= 1'b0;
      tag_sol   <= 1'b0;
      tag_eol   <= 1'b0;
    end else begin
      tag_valid <= issue && !abort;
      if (issue && !abort) begin
        tag_row   <= row;
        tag_col   <= col;
        tag_phase <= {row[0], col[0]} ^ BAYER;
        tag_sof   <= (row == '0) && (col == '0);
        tag_eof   <= last;
        tag_sol   <= (col == '0);
        tag_eol   <= (col == COL_W'(WIDTH - 1));
      end
    end
  end

endmodule

// File: tb/tb_cfa_scan_ctrl.sv
// Scoreboard bench for cfa_scan_ctrl on a 4x3 frame: stimulus queues expected
// addresses/tags/done cycles, a negedge monitor pops and compares them.
module tb_cfa_scan_ctrl;

  localparam int W = 4;
  localparam int H = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic hold = 1'b0;

  logic        mem_en, tag_valid, tag_sof, tag_eof, tag_sol, tag_eol, busy, done;
  logic [16:0] mem_addr;
  logic [1:0]  tag_row, tag_col, tag_phase;

  logic        b_mem_en, b_tag_valid, b_sof, b_eof, b_sol, b_eol, b_busy, b_done;
  logic [16:0] b_mem_addr;
  logic [1:0]  b_row, b_col, b_phase;

  cfa_scan_ctrl #(
    .WIDTH(W), .HEIGHT(H), .ADDR_W(17), .COL_W(2), .ROW_W(2), .BAYER(2'b00)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .hold(hold),
    .mem_en(mem_en), .mem_addr(mem_addr), .tag_valid(tag_valid),
    .tag_row(tag_row), .tag_col(tag_col), .tag_phase(tag_phase),
    .tag_sof(tag_sof), .tag_eof(tag_eof), .tag_sol(tag_sol), .tag_eol(tag_eol),
    .busy(busy), .done(done)
  );

  cfa_scan_ctrl #(
    .WIDTH(W), .HEIGHT(H), .ADDR_W(17), .COL_W(2), .ROW_W(2), .BAYER(2'b01)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .hold(hold),
    .mem_en(b_mem_en), .mem_addr(b_mem_addr), .tag_valid(b_tag_valid),
    .tag_row(b_row), .tag_col(b_col), .tag_phase(b_phase),
    .tag_sof(b_sof), .tag_eof(b_eof), .tag_sol(b_sol), .tag_eol(b_eol),
    .busy(b_busy), .done(b_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  logic [16:0] addr_q[$];
  logic [9:0]  tag_q[$];
  logic [1:0]  phb_q[$];
  int          done_q[$];

  logic [30:0] all_outs;
  assign all_outs = {mem_en, mem_addr, tag_valid, tag_row, tag_col, tag_phase,
                     tag_sof, tag_eof, tag_sol, tag_eol, busy, done};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  // Tag layout: row[9:8] col[7:6] phase[5:4] sof eof sol eol
  function automatic logic [9:0] exp_tag(input int i, input logic [1:0] bay);
    logic [1:0] r, c, ph;
    r  = 2'(i / W);
    c  = 2'(i % W);
    ph = {r[0], c[0]} ^ bay;
    return {r, c, ph, (i == 0), (i == W*H-1), (c == 2'd0), (c == 2'(W-1))};
  endfunction

  task automatic push_frame(input int n_addr, input int n_tag, input int done_cyc);
    logic [9:0] t;
    for (int i = 0; i < n_addr; i++) addr_q.push_back(17'(i));
    for (int i = 0; i < n_tag; i++) begin
      tag_q.push_back(exp_tag(i, 2'b00));
      t = exp_tag(i, 2'b01);
      phb_q.push_back(t[5:4]);
    end
    if (done_cyc >= 0) done_q.push_back(done_cyc);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 60 && busy; i++) tick;
    check("frame_end_busy", busy, 0);
    repeat (2) tick;
    check("queues_empty", addr_q.size() + tag_q.size() + phb_q.size() + done_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (mem_en) begin
      if (addr_q.size() == 0) check("addr_extra", 1, 0);
      else check("addr", mem_addr, addr_q.pop_front());
    end
    if (tag_valid) begin
      if (tag_q.size() == 0) check("tag_extra", 1, 0);
      else check("tag", {tag_row, tag_col, tag_phase, tag_sof, tag_eof, tag_sol, tag_eol},
                 tag_q.pop_front());
    end
    if (b_tag_valid) begin
      if (phb_q.size() == 0) check("phase_b_extra", 1, 0);
      else check("phase_b", b_phase, phb_q.pop_front());
    end
    if (done) begin
      if (done_q.size() == 0) check("done_extra", 1, 0);
      else check("done_cycle", cyc, done_q.pop_front());
    end
  end

  initial begin
    #1 rst = 1'b0;
    #2 check("reset_outs", all_outs, 0);
    tick;
    tick;
    rst = 1'b1;
    tick;

    // Plain frame: addresses 0..11 back to back, done 14 cycles after accept
    push_frame(12, 12, cyc + 14);
    start = 1'b1; tick; start = 1'b0;
    wait_idle;

    // Hold for 3 cycles exactly where address 6 would issue
    push_frame(12, 12, cyc + 17);
    start = 1'b1; tick; start = 1'b0;
    repeat (6) tick;
    hold = 1'b1;
    for (int j = 0; j < 3; j++) begin
      #2;
      check("hold_mem_en", mem_en, 0);
      check("hold_addr", mem_addr, 6);
      tick;
    end
    hold = 1'b0;
    wait_idle;

    // Abort while address 5 issues; its tag must not appear
    push_frame(6, 5, -1);
    start = 1'b1; tick; start = 1'b0;
    repeat (5) tick;
    abort = 1'b1; tick; abort = 1'b0;
    #2;
    check("abort_busy", busy, 0);
    check("abort_mem_en", mem_en, 0);
    check("abort_tag_valid", tag_valid, 0);
    tick;
    push_frame(12, 12, cyc + 14);
    start = 1'b1; tick; start = 1'b0;
    wait_idle;

    // Reset mid-frame while address 7 issues
    push_frame(8, 7, -1);
    start = 1'b1; tick; start = 1'b0;
    repeat (7) tick;
    @(negedge clk);
    #1 rst = 1'b0;
    #1 check("midreset_outs", all_outs, 0);
    tick;
    start = 1'b1; tick; start = 1'b0;
    #2 check("reset_start_ignored", busy, 0);
    tick;
    rst = 1'b1;
    tick;
    check("post_reset_idle", busy, 0);
    push_frame(12, 12, cyc + 14);
    start = 1'b1; tick; start = 1'b0;
    wait_idle;

    // Re-pulsed start during RUN must not disturb the sequence
    push_frame(12, 12, cyc + 14);
    start = 1'b1; tick; start = 1'b0;
    repeat (3) tick;
    start = 1'b1; tick; start = 1'b0;
    wait_idle;

    // start and abort together in IDLE: abort wins
    start = 1'b1; abort = 1'b1; tick; start = 1'b0; abort = 1'b0;
    #2;
    check("start_abort_busy", busy, 0);
    check("start_abort_mem_en", mem_en, 0);
    repeat (3) tick;
    check("start_abort_idle", busy, 0);
    check("final_queues_empty", addr_q.size() + tag_q.size() + phb_q.size() + done_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
